// File: rtl/color_palette_stage.sv
// Palette lookup stage: 2-bit pixel indices in, 24-bit RGB out, through a two-stage
// valid/ready pipeline whose colour table is reloaded from the register bank only at frame start.
module color_palette_stage #(
    parameter int NUM_COLORS = 4,
    parameter int IDX_W      = 2,
    parameter int REG_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [NUM_COLORS*REG_W-1:0] cfg_color_i,
    input  logic                        cfg_commit_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [IDX_W-1:0]            s_idx_i,
    input  logic                        s_sof_i,
    input  logic                        s_eol_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [23:0]                 m_rgb_o,
    output logic                        m_transp_o,
    output logic                        m_sof_o,
    output logic                        m_eol_o,
    output logic [CNT_W-1:0]            frame_cnt_o
);

    // Only colour (23:0) and transparency (24) are kept from each register.
    localparam int ENT_W = 25;

    logic [ENT_W-1:0] shadow_r [NUM_COLORS];
    logic             pending_r;
    logic             s1_v_r;
    logic [IDX_W-1:0] s1_idx_r;
    logic             s1_sof_r;
    logic             s1_eol_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic             load_s;
    logic [ENT_W-1:0] entry_s;

    assign s2_adv_s  = !m_valid_o || m_ready_i;
    assign s1_adv_s  = s1_v_r && s2_adv_s;
    assign s_ready_o = !s1_v_r || s1_adv_s;
    assign accept_s  = s_valid_i && s_ready_o;
    assign load_s    = accept_s && s_sof_i && (pending_r || cfg_commit_i);
    // Read before this edge's shadow update, so the old frame's tail keeps its colours.
    assign entry_s   = shadow_r[s1_idx_r];

    // Shadow palette: copied from the live bank only when a frame starts with a commit outstanding.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_COLORS; k++) begin
                shadow_r[k] <= {ENT_W{1'b0}};
            end
        end else if (load_s) begin
            for (int k = 0; k < NUM_COLORS; k++) begin
                shadow_r[k] <= cfg_color_i[k*REG_W +: ENT_W];
            end
        end
    end

    // Commit tracking; reset leaves it set so the first frame always loads.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending_r <= 1'b1;
        end else if (load_s) begin
            pending_r <= 1'b0;
        end else if (cfg_commit_i) begin
            pending_r <= 1'b1;
        end
    end

    // Stage 1: holds the accepted index and its frame markers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_v_r   <= 1'b0;
            s1_idx_r <= {IDX_W{1'b0}};
            s1_sof_r <= 1'b0;
            s1_eol_r <= 1'b0;
        end else if (s_ready_o) begin
            s1_v_r <= s_valid_i;
            if (s_valid_i) begin
                s1_idx_r <= s_idx_i;
                s1_sof_r <= s_sof_i;
                s1_eol_r <= s_eol_i;
            end
        end
    end

    // Stage 2: registered output pixel, looked up on the S1->S2 transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_valid_o  <= 1'b0;
            m_rgb_o    <= 24'h000000;
            m_transp_o <= 1'b0;
            m_sof_o    <= 1'b0;
            m_eol_o    <= 1'b0;
        end else if (s2_adv_s) begin
            m_valid_o <= s1_v_r;
            if (s1_v_r) begin
                m_rgb_o    <= entry_s[23:0];
                m_transp_o <= entry_s[24];
                m_sof_o    <= s1_sof_r;
                m_eol_o    <= s1_eol_r;
            end
        end
    end

    // Frame counter: one per accepted SOF pixel, wrapping naturally.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt_o <= {CNT_W{1'b0}};
        end else if (accept_s && s_sof_i) begin
            frame_cnt_o <= frame_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_color_palette_stage.sv
// Directed bench for color_palette_stage: a pixel-queue model checked every cycle,
// plus literal expectations for the reset, tear-free update, boundary, back-pressure, wrap and reset cases.
module tb_color_palette_stage;

    localparam int NC = 4;
    localparam int RW = 32;
    localparam int CW = 4;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [NC*RW-1:0] cfg;
    logic            commit = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [1:0]      s_idx = 2'd0;
    logic            s_sof = 1'b0;
    logic            s_eol = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [23:0]     m_rgb;
    logic            m_transp;
    logic            m_sof;
    logic            m_eol;
    logic [CW-1:0]   frame_cnt;

    color_palette_stage #(.NUM_COLORS(NC), .IDX_W(2), .REG_W(RW), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_color_i(cfg), .cfg_commit_i(commit),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_idx_i(s_idx), .s_sof_i(s_sof),
        .s_eol_i(s_eol), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_rgb_o(m_rgb),
        .m_transp_o(m_transp), .m_sof_o(m_sof), .m_eol_o(m_eol), .frame_cnt_o(frame_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [23:0] rgb;
        logic        transp;
        logic        sof;
        logic        eol;
        logic        vis;
    } pix_t;

    pix_t        q[$];
    logic [24:0] sh [NC];
    logic        pend = 1'b1;
    logic [CW-1:0] cnt = '0;
    bit          acc_m;
    pix_t        p_m;
    bit          exp_v;

    int total = 0;
    int bad = 0;
    logic [23:0] log_rgb[$];
    logic        log_tr[$];
    bit pat_en = 1'b0;
    int pat_k = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] lr(input int i);
        return (i < log_rgb.size()) ? log_rgb[i] : 24'hxxxxxx;
    endfunction

    function automatic logic lt(input int i);
        return (i < log_tr.size()) ? log_tr[i] : 1'bx;
    endfunction

    // Model: pixels take the palette in force for their frame at acceptance; the queue holds what is in flight.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q.delete();
            for (int k = 0; k < NC; k++) sh[k] = 25'd0;
            pend = 1'b1;
            cnt  = '0;
        end else begin
            acc_m = s_valid && ((q.size() < 2) || m_ready);
            if (acc_m && s_sof && (pend || commit)) begin
                for (int k = 0; k < NC; k++) sh[k] = cfg[k*RW +: 25];
                pend = 1'b0;
            end else if (commit) begin
                pend = 1'b1;
            end
            if (acc_m) begin
                p_m.rgb    = sh[s_idx][23:0];
                p_m.transp = sh[s_idx][24];
                p_m.sof    = s_sof;
                p_m.eol    = s_eol;
                p_m.vis    = 1'b0;
                if (s_sof) cnt = cnt + 1'b1;
            end
            if (q.size() > 0 && q[0].vis && m_ready) void'(q.pop_front());
            if (q.size() > 0) q[0].vis = 1'b1;
            if (acc_m) q.push_back(p_m);
        end
    end

    // Compare process: every negedge, outputs against the model.
    always @(negedge ACLK) begin
        exp_v = (q.size() > 0) && q[0].vis;
        chk("m_valid", m_valid, exp_v);
        if (exp_v) begin
            chk("m_rgb", m_rgb, q[0].rgb);
            chk("m_transp", m_transp, q[0].transp);
            chk("m_sof", m_sof, q[0].sof);
            chk("m_eol", m_eol, q[0].eol);
        end
        chk("s_ready", s_ready, (q.size() < 2) || m_ready);
        chk("frame_cnt", frame_cnt, cnt);
        if (m_valid && m_ready) begin
            log_rgb.push_back(m_rgb);
            log_tr.push_back(m_transp);
        end
    end

    // Output-ready pattern 1,0,0,1 for the back-pressure run.
    always @(posedge ACLK) begin
        if (pat_en) begin
            #1;
            m_ready = ((pat_k % 4) == 0) || ((pat_k % 4) == 3);
            pat_k++;
        end
    end

    task automatic send(input logic [1:0] idx, input logic sof, input logic eol);
        int n;
        bit rdy;
        s_valid = 1'b1; s_idx = idx; s_sof = sof; s_eol = eol;
        n = 0;
        do begin
            @(negedge ACLK);
            rdy = s_ready;
            @(posedge ACLK);
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL send_timeout idx=%0d waited=%0d cycles, required acceptance", idx, n);
        end
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    task automatic do_commit(input int entry, input logic [31:0] val);
        cfg[entry*RW +: RW] = val;
        commit = 1'b1;
        @(posedge ACLK);
        #1 commit = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge ACLK);
        #1;
    endtask

    initial begin
        logic [CW-1:0] fc [18];
        cfg = {32'h01FFFFFF, 32'h000000FF, 32'h0000FF00, 32'h00FF0000};

        // T1 reset values then first frame
        @(negedge ACLK);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_rgb", m_rgb, 24'h000000);
        chk("rst_m_transp", m_transp, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 4'd0);
        @(posedge ACLK);
        #3 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        log_rgb.delete(); log_tr.delete();
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b1);
        drain();
        chk("t1_count", log_rgb.size(), 32'd4);
        chk("t1_rgb0", lr(0), 24'hFF0000);
        chk("t1_rgb1", lr(1), 24'h00FF00);
        chk("t1_rgb2", lr(2), 24'h0000FF);
        chk("t1_rgb3", lr(3), 24'hFFFFFF);
        chk("t1_tr0", lt(0), 1'b0);
        chk("t1_tr2", lt(2), 1'b0);
        chk("t1_tr3", lt(3), 1'b1);
        chk("t1_frame_cnt", frame_cnt, 4'd1);

        // T2 commit mid-frame, visible only from next SOF
        log_rgb.delete(); log_tr.delete();
        do_commit(1, 32'h00123456);
        send(2'd1, 1'b0, 1'b0);
        send(2'd1, 1'b1, 1'b0);
        drain();
        chk("t2_old", lr(0), 24'h00FF00);
        chk("t2_new", lr(1), 24'h123456);
        chk("t2_frame_cnt", frame_cnt, 4'd2);

        // T3 last pixel stalled in S1 while loading SOF is accepted
        do_commit(1, 32'h0000FF00);
        send(2'd0, 1'b1, 1'b0);
        do_commit(1, 32'h00123456);
        drain();
        log_rgb.delete(); log_tr.delete();
        m_ready = 1'b0;
        send(2'd2, 1'b0, 1'b0);
        send(2'd1, 1'b0, 1'b1);
        fork
            send(2'd1, 1'b1, 1'b0);
            begin
                repeat (2) @(posedge ACLK);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        chk("t3_count", log_rgb.size(), 32'd3);
        chk("t3_first", lr(0), 24'h0000FF);
        chk("t3_tail", lr(1), 24'h00FF00);
        chk("t3_sof", lr(2), 24'h123456);

        // T4 back-pressure with ready pattern 1,0,0,1
        log_rgb.delete(); log_tr.delete();
        pat_k = 0;
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++) send(2'(i % 4), i == 0, i == 7);
        pat_en = 1'b0;
        @(posedge ACLK);
        #2 m_ready = 1'b1;
        @(posedge ACLK);
        #1;
        drain();
        chk("t4_count", log_rgb.size(), 32'd8);
        chk("t4_rgb1", lr(1), 24'h123456);
        chk("t4_rgb7", lr(7), 24'hFFFFFF);
        chk("t4_tr7", lt(7), 1'b1);

        // T6 async reset between edges, then reload of the current bank
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        #1 chk("t6_pre_valid", m_valid, 1'b1);
        ARESETN = 1'b0;
        #1 chk("t6_rst_valid", m_valid, 1'b0);
        cfg[2*RW +: RW] = 32'h00ABCDEF;
        @(posedge ACLK);
        #3 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        log_rgb.delete(); log_tr.delete();
        send(2'd2, 1'b1, 1'b0);
        drain();
        chk("t6_reload", lr(0), 24'hABCDEF);
        chk("t6_frame_cnt", frame_cnt, 4'd1);

        // T5 counter wrap from a fresh reset
        #1 ARESETN = 1'b0;
        @(posedge ACLK);
        #3 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        for (int i = 1; i <= 17; i++) begin
            send(2'(i % 4), 1'b1, 1'b0);
            fc[i] = frame_cnt;
        end
        chk("t5_cnt15", fc[15], 4'd15);
        chk("t5_cnt16", fc[16], 4'd0);
        chk("t5_cnt17", fc[17], 4'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
